// File: rtl/out_data_pkg.sv
// Shared size-code definitions for the load-data formatter.
package out_data_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_RSVD = 2'd2,
        SZ_WORD = 2'd3
    } size_t;

endpackage

// File: rtl/out_data_ext.sv
// Combinational extractor/extender: right-aligned byte/half/word to 32 bits.
module out_data_ext
    import out_data_pkg::*;
(
    input  logic [0:31] rawMemOut,
    input  logic [0:1]  DSize,
    input  logic        loadSign,
    output logic [0:31] result
);

    size_t size;

    always_comb begin
        size   = size_t'(DSize);
        result = rawMemOut;
        case (size)
            SZ_BYTE: result = {{24{loadSign & rawMemOut[24]}}, rawMemOut[24:31]};
            SZ_HALF: result = {{16{loadSign & rawMemOut[16]}}, rawMemOut[16:31]};
            // reserved code formats as a full word
            default: result = rawMemOut;
        endcase
    end

endmodule

// File: rtl/out_data.sv
// Registered load-data formatter with valid qualifier.
// Optional sizeErr output enabled by macro OUT_DATA_SIZE_ERR_EN.
module out_data
    import out_data_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [0:31] rawMemOut,
    input  logic [0:1]  DSize,
    input  logic        loadSign,
    input  logic        memValid,
    output logic [0:31] dataOut,
    output logic        dataValid
`ifdef OUT_DATA_SIZE_ERR_EN
    ,
    output logic        sizeErr
`endif
);

    logic [0:31] formatted;

    out_data_ext u_ext (
        .rawMemOut (rawMemOut),
        .DSize     (DSize),
        .loadSign  (loadSign),
        .result    (formatted)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dataOut   <= '0;
            dataValid <= 1'b0;
        end else begin
            dataOut   <= formatted;
            dataValid <= memValid;
        end
    end

`ifdef OUT_DATA_SIZE_ERR_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sizeErr <= 1'b0;
        end else begin
            sizeErr <= memValid & (size_t'(DSize) == SZ_RSVD);
        end
    end
`endif

endmodule

// File: tb/tb_out_data.sv
// Self-checking bench for out_data: directed table, reset sequences, random vs model.
module tb_out_data;

    logic        clk;
    logic        reset;
    logic [0:31] rawMemOut;
    logic [0:1]  DSize;
    logic        loadSign;
    logic        memValid;
    logic [0:31] dataOut;
    logic        dataValid;
`ifdef OUT_DATA_SIZE_ERR_EN
    logic        sizeErr;
`endif

    int unsigned vectors;
    int unsigned miscompares;

    out_data dut (
        .clk       (clk),
        .reset     (reset),
        .rawMemOut (rawMemOut),
        .DSize     (DSize),
        .loadSign  (loadSign),
        .memValid  (memValid),
        .dataOut   (dataOut),
        .dataValid (dataValid)
`ifdef OUT_DATA_SIZE_ERR_EN
        ,
        .sizeErr   (sizeErr)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] raw;
        logic [1:0]  sz;
        logic        sgn;
        logic        vld;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [17];

    // Reference: pick the low item numerically, then extend by arithmetic.
    function automatic logic [31:0] model(logic [31:0] raw, logic [1:0] sz, logic sgn);
        logic [31:0] v;
        case (sz)
            2'd0: begin
                v = raw % 32'd256;
                if (sgn && v >= 32'd128) v = v + 32'hFFFF_FF00;
            end
            2'd1: begin
                v = raw % 32'd65536;
                if (sgn && v >= 32'd32768) v = v + 32'hFFFF_0000;
            end
            default: v = raw;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] raw, input logic [1:0] sz, input logic sgn, input logic vld);
        rawMemOut = raw;
        DSize     = sz;
        loadSign  = sgn;
        memValid  = vld;
    endtask

    task automatic check_outputs(input string name, input logic [31:0] exp_out, input logic exp_vld,
                                 input logic exp_err);
        chk({name, ".dataOut"}, dataOut, exp_out);
        chk({name, ".dataValid"}, {31'd0, dataValid}, {31'd0, exp_vld});
`ifdef OUT_DATA_SIZE_ERR_EN
        chk({name, ".sizeErr"}, {31'd0, sizeErr}, {31'd0, exp_err});
`else
        if (exp_err === 1'bx) $display("unexpected X flag in %s", name);
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;

        tbl[0]  = '{32'hf1234567, 2'd0, 1'b0, 1'b1, 32'h00000067};
        tbl[1]  = '{32'hf1234567, 2'd0, 1'b1, 1'b1, 32'h00000067};
        tbl[2]  = '{32'h000000f1, 2'd0, 1'b0, 1'b1, 32'h000000f1};
        tbl[3]  = '{32'h000000f1, 2'd0, 1'b1, 1'b1, 32'hfffffff1};
        tbl[4]  = '{32'hf1238567, 2'd1, 1'b0, 1'b1, 32'h00008567};
        tbl[5]  = '{32'hf1238567, 2'd1, 1'b1, 1'b1, 32'hffff8567};
        tbl[6]  = '{32'hf1234567, 2'd1, 1'b0, 1'b1, 32'h00004567};
        tbl[7]  = '{32'hf1234567, 2'd1, 1'b1, 1'b1, 32'h00004567};
        tbl[8]  = '{32'hf1234567, 2'd3, 1'b0, 1'b1, 32'hf1234567};
        tbl[9]  = '{32'hf1234567, 2'd3, 1'b1, 1'b1, 32'hf1234567};
        tbl[10] = '{32'hf1234567, 2'd2, 1'b0, 1'b1, 32'hf1234567};
        tbl[11] = '{32'hf1234567, 2'd2, 1'b1, 1'b1, 32'hf1234567};
        tbl[12] = '{32'h00000080, 2'd0, 1'b1, 1'b1, 32'hffffff80};
        tbl[13] = '{32'h0000007f, 2'd0, 1'b1, 1'b0, 32'h0000007f};
        tbl[14] = '{32'h00008000, 2'd1, 1'b1, 1'b1, 32'hffff8000};
        tbl[15] = '{32'haaaabbbb, 2'd3, 1'b0, 1'b0, 32'haaaabbbb};
        tbl[16] = '{32'h12345678, 2'd0, 1'b1, 1'b1, 32'h00000078};

        // Asynchronous reset assertion with live inputs present
        reset = 1'b0;
        drive(32'hf1234567, 2'd3, 1'b0, 1'b1);
        #2 reset = 1'b1;
        #1 check_outputs("reset_async", 32'h0, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_outputs("reset_held", 32'h0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_outputs("first_after_release", 32'hf1234567, 1'b1, 1'b0);

        for (int i = 0; i < 17; i++) begin
            @(negedge clk) drive(tbl[i].raw, tbl[i].sz, tbl[i].sgn, tbl[i].vld);
            @(posedge clk); #1;
            check_outputs($sformatf("tbl[%0d]", i), tbl[i].exp, tbl[i].vld,
                          tbl[i].vld & (tbl[i].sz == 2'd2));
        end

        // Reset mid-operation discards the in-flight value
        @(negedge clk) drive(32'hdeadbeef, 2'd3, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_outputs("pre_midreset", 32'hdeadbeef, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 check_outputs("midreset_async", 32'h0, 1'b0, 1'b0);
        @(negedge clk) drive(32'h000000f1, 2'd0, 1'b1, 1'b1);
        @(posedge clk); #1;
        check_outputs("midreset_held", 32'h0, 1'b0, 1'b0);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        check_outputs("midreset_release", 32'hfffffff1, 1'b1, 1'b0);

        for (int i = 0; i < 300; i++) begin
            logic [31:0] r;
            logic [1:0]  s;
            logic        g;
            logic        v;
            r = $urandom;
            if ($urandom_range(0, 3) == 0) r[7] = 1'b1;
            if ($urandom_range(0, 3) == 0) r[15] = 1'b1;
            s = 2'($urandom_range(0, 3));
            g = 1'($urandom_range(0, 1));
            v = 1'($urandom_range(0, 1));
            @(negedge clk) drive(r, s, g, v);
            @(posedge clk); #1;
            check_outputs($sformatf("rand[%0d]", i), model(r, s, g), v, v & (s == 2'd2));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/out_data.md
Name: out_data

Overview:
- Load-data formatter between data memory and register-file write-back.
- Takes the raw 32-bit memory word and extracts a byte, halfword or word according to the access size.
- Zero- or sign-extends the result to 32 bits.
- Output is registered: one cycle of latency, with a valid qualifier.

Parameters:
- none (widths fixed at 32-bit data, 2-bit size code)

Ports:
- clk  input  1  system clock, rising-edge active
- reset  input  1  asynchronous, active-high reset
- rawMemOut  input  [0:31]  raw memory read word; bit 0 = MSB, bits [24:31] = least-significant byte
- DSize  input  [0:1]  access size: 0 = byte, 1 = halfword, 2 = reserved, 3 = word
- loadSign  input  1  1 = sign-extend, 0 = zero-extend
- memValid  input  1  rawMemOut/DSize/loadSign are valid this cycle
- dataOut  output  [0:31]  formatted load data, registered
- dataValid  output  1  dataOut valid; registered copy of memValid

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset: dataOut = 32'h0 and dataValid = 0 immediately on reset assertion, held while reset is high.
- Alignment: memory delivers the addressed item right-aligned, so no byte/half lane selection is done here.
  - Byte = rawMemOut[24:31].
  - Half = rawMemOut[16:31].
- Byte (DSize=0):
  - loadSign=0: dataOut[0:23] = 0.
  - loadSign=1: dataOut[0:23] = rawMemOut[24].
  - dataOut[24:31] = rawMemOut[24:31] in both cases.
- Half (DSize=1):
  - loadSign=0: dataOut[0:15] = 0.
  - loadSign=1: dataOut[0:15] = rawMemOut[16].
  - dataOut[16:31] = rawMemOut[16:31] in both cases.
- Word (DSize=3): dataOut = rawMemOut; loadSign ignored.
- Reserved (DSize=2): treated exactly as word.
- Latency:
  - On each rising clk with reset low, dataOut <= formatted value of the current inputs and dataValid <= memValid.
  - Total latency is one cycle.
- memValid=0: dataOut still updates; dataValid=0 tells consumers to ignore it. No stall or backpressure.
- Reset mid-operation: any in-flight value is discarded. The first output after reset release comes from the inputs sampled at the first rising edge with reset low.
- No X propagation from DSize: any 2-bit code maps to a defined result.

Optional Feature:
- Macro OUT_DATA_SIZE_ERR_EN.
- Defined:
  - Adds output port sizeErr (1 bit, registered, reset 0).
  - sizeErr <= memValid & (DSize==2).
  - dataOut for DSize=2 is still the word result.
- Undefined:
  - Port is absent.
  - DSize=2 is silently treated as word.

Decomposition:
- Shared package out_data_pkg:
  - Size-code constants SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_RSVD=2'd2, SZ_WORD=2'd3.
  - A typedef for the 2-bit size code.
- One natural sub-module: out_data_ext, a purely combinational extractor/extender (rawMemOut, DSize, loadSign -> 32-bit result).
- out_data wraps out_data_ext with the output and valid registers.

Test Plan:
- Reset asserted with rawMemOut=32'hf1234567, memValid=1 -> dataOut=0, dataValid=0 asynchronously; values appear one cycle after release.
- rawMemOut=32'hf1234567, DSize=0, loadSign=0 then 1 -> 32'h00000067 both times (bit 24 clear).
- rawMemOut=32'h000000f1, DSize=0: loadSign=0 -> 32'h000000f1; loadSign=1 -> 32'hfffffff1.
- rawMemOut=32'hf1238567, DSize=1: loadSign=0 -> 32'h00008567; loadSign=1 -> 32'hffff8567. With 32'hf1234567 both give 32'h00004567.
- rawMemOut=32'hf1234567, DSize=3 and DSize=2, loadSign toggled -> 32'hf1234567 every cycle. With OUT_DATA_SIZE_ERR_EN, sizeErr=1 only for DSize=2 with memValid=1.
- memValid pattern 1,0,1 over three cycles -> dataValid 1,0,1 one cycle later; dataOut tracks the inputs each cycle.
